// File: rtl/pll_lock_supervisor_if.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_supervisor_if
// Description : PLL-side and status signals of the PLL lock supervisor.
//               The slave modport is the supervisor's view. The master
//               modport is the environment's view (PLL model / system).
// Revision    : 1.0 - initial release
// ============================================================================
interface pll_lock_supervisor_if;
    logic       locked;     // raw PLL lock, asynchronous to refclk
    logic       pll_rst;    // reset to the PLL, active-high
    logic       sys_rst;    // system reset, active-high
    logic [1:0] state;      // 0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN
    logic [3:0] retry_cnt;  // lock-timeout retries, saturating
    logic [7:0] loss_cnt;   // run-time lock losses, saturating

    modport slave (
        input  locked,
        output pll_rst,
        output sys_rst,
        output state,
        output retry_cnt,
        output loss_cnt
    );

    modport master (
        output locked,
        input  pll_rst,
        input  sys_rst,
        input  state,
        input  retry_cnt,
        input  loss_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_supervisor
// Description : Drives the PLL reset, synchronizes its lock output and
//               releases a clean system reset only after lock has been held
//               for STABLE_CYCLES. Retries on lock timeout.
//               Optional feature macro: PLL_SUP_AUTO_RELOCK_EN
//                 defined   - a lock loss in RUN re-sequences automatically
//                 undefined - a lock loss in RUN freezes in RESET_PLL until rst
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES = 16,
    parameter int LOCK_TIMEOUT     = 50000,
    parameter int STABLE_CYCLES    = 1024
) (
    input  wire logic              refclk,
    input  wire logic              rst,
    pll_lock_supervisor_if.slave   bus
);

    // Timer is sized for the largest terminal count it must reach.
    localparam int c_MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES : LOCK_TIMEOUT;
    localparam int c_MAX_P = (c_MAX_A > STABLE_CYCLES) ? c_MAX_A : STABLE_CYCLES;
    localparam int c_TW    = (c_MAX_P > 2) ? $clog2(c_MAX_P) : 1;

    localparam logic [c_TW-1:0] c_RST_LAST    = c_TW'(RST_PULSE_CYCLES - 1);
    localparam logic [c_TW-1:0] c_TIMEOUT_LAST = c_TW'(LOCK_TIMEOUT - 1);
    localparam logic [c_TW-1:0] c_STABLE_LAST = c_TW'(STABLE_CYCLES - 1);

    localparam logic [1:0] RESET_PLL = 2'd0;
    localparam logic [1:0] WAIT_LOCK = 2'd1;
    localparam logic [1:0] STABLE    = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;

    logic            r_lock_meta;
    logic            r_lock_s;
    logic [1:0]      r_state;
    logic [c_TW-1:0] r_timer;
    logic            r_fault;
    logic            r_pll_rst;
    logic            r_sys_rst;
    logic [3:0]      r_retry_cnt;
    logic [7:0]      r_loss_cnt;

    logic [1:0]      w_next_state;
    logic [c_TW-1:0] w_next_timer;
    logic            w_next_fault;
    logic            w_retry_inc;
    logic            w_loss_inc;

    // Two-flop synchronizer bringing the asynchronous lock into refclk.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= bus.locked;
            r_lock_s    <= r_lock_meta;
        end
    end

    // Next-state, timer and counter-event decode.
    always_comb begin
        w_next_state = r_state;
        w_next_timer = r_timer + 1'b1;
        w_next_fault = r_fault;
        w_retry_inc  = 1'b0;
        w_loss_inc   = 1'b0;
        case (r_state)
            RESET_PLL: begin
                if (r_fault) begin
                    // Frozen after a run-time lock loss: hold everything.
                    w_next_timer = r_timer;
                end else if (r_timer == c_RST_LAST) begin
                    w_next_state = WAIT_LOCK;
                    w_next_timer = '0;
                end
            end
            WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (r_lock_s) begin
                    w_next_state = STABLE;
                    w_next_timer = '0;
                end else if (r_timer == c_TIMEOUT_LAST) begin
                    w_next_state = RESET_PLL;
                    w_next_timer = '0;
                    w_retry_inc  = 1'b1;
                end
            end
            STABLE: begin
                if (!r_lock_s) begin
                    w_next_state = WAIT_LOCK;
                    w_next_timer = '0;
                end else if (r_timer == c_STABLE_LAST) begin
                    w_next_state = RUN;
                    w_next_timer = '0;
                end
            end
            default: begin
                // RUN does not time anything; keep the timer parked at zero.
                w_next_timer = '0;
                if (!r_lock_s) begin
                    w_next_state = RESET_PLL;
                    w_loss_inc   = 1'b1;
`ifdef PLL_SUP_AUTO_RELOCK_EN
                    w_next_fault = 1'b0;
`else
                    w_next_fault = 1'b1;
`endif
                end
            end
        endcase
    end

    // State, timer and registered output decode (outputs follow the next state
    // so they change on the same edge as the state register).
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state   <= RESET_PLL;
            r_timer   <= '0;
            r_fault   <= 1'b0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
        end else begin
            r_state   <= w_next_state;
            r_timer   <= w_next_timer;
            r_fault   <= w_next_fault;
            r_pll_rst <= (w_next_state == RESET_PLL);
            r_sys_rst <= (w_next_state != RUN);
        end
    end

    // Saturating retry and lock-loss counters.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_retry_cnt <= '0;
            r_loss_cnt  <= '0;
        end else begin
            if (w_retry_inc && (r_retry_cnt != 4'hF)) begin
                r_retry_cnt <= r_retry_cnt + 4'd1;
            end
            if (w_loss_inc && (r_loss_cnt != 8'hFF)) begin
                r_loss_cnt <= r_loss_cnt + 8'd1;
            end
        end
    end

    assign bus.pll_rst   = r_pll_rst;
    assign bus.sys_rst   = r_sys_rst;
    assign bus.state     = r_state;
    assign bus.retry_cnt = r_retry_cnt;
    assign bus.loss_cnt  = r_loss_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_supervisor
// Description : Self-checking bench for pll_lock_supervisor with
//               RST_PULSE_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;

    logic refclk;
    logic rst;
    int   n_checks;
    int   n_fails;

    pll_lock_supervisor_if bus ();

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES (4),
        .LOCK_TIMEOUT     (20),
        .STABLE_CYCLES    (8)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    typedef struct {
        logic       rst;
        logic       locked;
        logic       pll;
        logic       sys;
        logic [1:0] st;
        logic [3:0] rc;
        logic [7:0] lc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic lk, input logic p, input logic s,
                       input logic [1:0] st, input logic [3:0] rc, input logic [7:0] lc);
        vec_t v;
        v.rst = r; v.locked = lk; v.pll = p; v.sys = s; v.st = st; v.rc = rc; v.lc = lc;
        tbl.push_back(v);
    endtask

    // Drive inputs mid-cycle, take one rising edge, sample 1 time unit later.
    task automatic step(input logic r, input logic lk);
        @(negedge refclk);
        rst        = r;
        bus.locked = lk;
        @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic p, input logic s,
                           input logic [1:0] st, input logic [3:0] rc, input logic [7:0] lc);
        chk({tag, ".pll_rst"},   int'(bus.pll_rst),   int'(p));
        chk({tag, ".sys_rst"},   int'(bus.sys_rst),   int'(s));
        chk({tag, ".state"},     int'(bus.state),     int'(st));
        chk({tag, ".retry_cnt"}, int'(bus.retry_cnt), int'(rc));
        chk({tag, ".loss_cnt"},  int'(bus.loss_cnt),  int'(lc));
    endtask

    initial begin
        n_checks   = 0;
        n_fails    = 0;
        rst        = 1'b1;
        bus.locked = 1'b0;

        // ---- Vector table ------------------------------------------------
        // k = number of edges since rst fell (vector k drives the input seen
        // at edge k, expected values are the outputs after edge k).
        // Segment 1: locked rises at k=10 -> STABLE at 12, RUN at 20.
        add(1, 0, 1, 1, 2'd0, 0, 0);
        add(1, 0, 1, 1, 2'd0, 0, 0);
        for (int k = 1; k <= 22; k++) begin
            logic [1:0] st;
            st = (k <= 3) ? 2'd0 : (k <= 11) ? 2'd1 : (k <= 19) ? 2'd2 : 2'd3;
            add(0, (k >= 10), (k <= 3), (k < 20), st, 0, 0);
        end
        // Segment 2: locked from k=1 (STABLE at 5), drops at k=8,9.
        // STABLE left at 10, re-entered at 12, RUN at 20.
        add(1, 0, 1, 1, 2'd0, 0, 0);
        add(1, 0, 1, 1, 2'd0, 0, 0);
        for (int k = 1; k <= 21; k++) begin
            logic [1:0] st;
            st = (k <= 3) ? 2'd0 : (k == 4) ? 2'd1 : (k <= 9) ? 2'd2 :
                 (k <= 11) ? 2'd1 : (k <= 19) ? 2'd2 : 2'd3;
            add(0, !(k == 8 || k == 9), (k <= 3), (k < 20), st, 0, 0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].locked);
            chk($sformatf("vec%0d.pll_rst", i), int'(bus.pll_rst), int'(tbl[i].pll));
            chk($sformatf("vec%0d.sys_rst", i), int'(bus.sys_rst), int'(tbl[i].sys));
            chk($sformatf("vec%0d.state", i),   int'(bus.state),   int'(tbl[i].st));
            if (i == 0 || tbl[i].st == 2'd3) begin
                chk($sformatf("vec%0d.retry", i), int'(bus.retry_cnt), int'(tbl[i].rc));
                chk($sformatf("vec%0d.loss", i),  int'(bus.loss_cnt),  int'(tbl[i].lc));
            end
        end

        // ---- Lock timeout retries and saturation --------------------------
        step(1, 0);
        step(1, 0);
        for (int k = 1; k <= 20 * 24; k++) begin
            step(0, 0);
            if (k == 23) chk("timeout.wait_before", int'(bus.state), 1);
            if (k == 24) begin
                chk("timeout.state_retry1", int'(bus.state), 0);
                chk("timeout.pll_retry1", int'(bus.pll_rst), 1);
            end
            if (k % 24 == 0 && k <= 72) chk($sformatf("timeout.retry_at_%0d", k),
                                            int'(bus.retry_cnt), k / 24);
            if (k == 47) chk("timeout.retry_still1", int'(bus.retry_cnt), 1);
        end
        chk("timeout.retry_saturated", int'(bus.retry_cnt), 15);

        // ---- rst pulse mid-STABLE after saturation ------------------------
        begin
            int budget;
            budget = 60;
            while (bus.state != 2'd2 && budget > 0) begin
                step(0, 1);
                budget--;
            end
            chk("pulse.reach_stable", int'(bus.state), 2);
            step(0, 1);
            step(0, 1);
            chk("pulse.still_stable", int'(bus.state), 2);
            step(1, 1);
            chk_all("pulse", 1'b1, 1'b1, 2'd0, 4'd0, 8'd0);
        end

        // ---- Lock loss in RUN ---------------------------------------------
        // locked from k=1: STABLE at 5, RUN at 13; drop at k=20..23.
        step(1, 0);
        for (int k = 1; k <= 19; k++) step(0, 1);
        chk_all("loss.run", 1'b0, 1'b0, 2'd3, 4'd0, 8'd0);
        step(0, 0);  // k=20
        step(0, 0);  // k=21
        chk_all("loss.edge2", 1'b0, 1'b0, 2'd3, 4'd0, 8'd0);
        step(0, 0);  // k=22
        chk_all("loss.edge3", 1'b1, 1'b1, 2'd0, 4'd0, 8'd1);
        step(0, 0);  // k=23
        for (int k = 24; k <= 40; k++) begin
            step(0, 1);
`ifdef PLL_SUP_AUTO_RELOCK_EN
            if (k == 26) chk("relock.wait", int'(bus.state), 1);
            if (k == 27) chk("relock.stable", int'(bus.state), 2);
            if (k == 34) chk("relock.sys_before", int'(bus.sys_rst), 1);
            if (k == 35) chk_all("relock.run", 1'b0, 1'b0, 2'd3, 4'd0, 8'd1);
`endif
        end
`ifndef PLL_SUP_AUTO_RELOCK_EN
        chk_all("freeze", 1'b1, 1'b1, 2'd0, 4'd0, 8'd1);
`endif
        // rst restarts the sequence from scratch.
        step(1, 1);
        chk_all("restart.reset", 1'b1, 1'b1, 2'd0, 4'd0, 8'd0);
        for (int k = 1; k <= 13; k++) begin
            step(0, 1);
            if (k == 12) chk("restart.sys_before", int'(bus.sys_rst), 1);
        end
        chk_all("restart.run", 1'b0, 1'b0, 2'd3, 4'd0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
